// File: rtl/sha_message_schedule_ctrl_if.sv
// Stream and expander-hookup signals of the SHA-256 message schedule controller.
// master = controller side, slave = front end / compression core / expander side.
interface sha_message_schedule_ctrl_if;
  logic              blk_valid_i;
  logic              blk_ready_o;
  logic [15:0][31:0] blk_i;
  logic              w_valid_o;
  logic              w_ready_i;
  logic [31:0]       w_o;
  logic [5:0]        w_idx_o;
  logic              w_last_o;
  logic              busy_o;
  logic [15:0][31:0] exp_hist_o;
  logic [15:0][31:0] exp_hist_i;

  modport master (
    input  blk_valid_i, blk_i, w_ready_i, exp_hist_i,
    output blk_ready_o, w_valid_o, w_o, w_idx_o, w_last_o, busy_o, exp_hist_o
  );

  modport slave (
    output blk_valid_i, blk_i, w_ready_i, exp_hist_i,
    input  blk_ready_o, w_valid_o, w_o, w_idx_o, w_last_o, busy_o, exp_hist_o
  );
endinterface

// File: rtl/sha_message_schedule_ctrl.sv
// Drives an external SHA-256 message expander to stream W0..W63 of one block.
// Owns the 16-word history window (index 0 = newest) and waits out the expander latency.
module sha_message_schedule_ctrl #(
  parameter int unsigned PIPELINE_DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  sha_message_schedule_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIPELINE_DEPTH - 1);

  if (PIPELINE_DEPTH < 1 || PIPELINE_DEPTH > 8) begin : g_bad_depth
    $error("sha_message_schedule_ctrl: PIPELINE_DEPTH must be in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t            state;
  logic [15:0][31:0] window;
  logic [5:0]        t;
  logic [CNT_W-1:0]  cnt;
  logic              w_valid_q;
  logic              w_last_q;
  logic [31:0]       w_data_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // in this block samples the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      // NOTE: the window is a flop array, not RAM, and must read zero on
      // exp_hist_o during reset, so it is cleared like any other register.
      window    <= '0;
      t         <= '0;
      cnt       <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      w_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid_i) begin
            for (int i = 0; i < 16; i++) begin
              window[i] <= bus.blk_i[15-i];
            end
            t         <= '0;
            w_data_q  <= bus.blk_i[0];
            w_valid_q <= 1'b1;
            w_last_q  <= 1'b0;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (bus.w_ready_i) begin
            if (t == 6'd63) begin
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
              state     <= IDLE;
            end else if (t < 6'd15) begin
              // Still replaying the message words held in the window.
              t        <= t + 6'd1;
              w_data_q <= window[4'd14 - t[3:0]];
            end else begin
              t         <= t + 6'd1;
              cnt       <= '0;
              w_valid_q <= 1'b0;
              state     <= STEP;
            end
          end
        end

        STEP: begin
          // The window has been stable for PIPELINE_DEPTH cycles when cnt hits
          // LAST_CNT, so the expander output now reflects it.
          if (cnt == LAST_CNT) begin
            window    <= bus.exp_hist_i;
            w_data_q  <= bus.exp_hist_i[0];
            w_valid_q <= 1'b1;
            w_last_q  <= (t == 6'd63);
            state     <= EMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps ready low while held in reset yet high on the
  // very first cycle after release.
  assign bus.blk_ready_o = (state == IDLE) && !rst;
  assign bus.busy_o      = (state != IDLE);
  assign bus.w_valid_o   = w_valid_q;
  assign bus.w_o         = w_data_q;
  assign bus.w_idx_o     = t;
  assign bus.w_last_o    = w_last_q;
  assign bus.exp_hist_o  = window;

endmodule

// File: tb/tb_sha_message_schedule_ctrl.sv
// Self-checking bench: three controllers (depth 1, 3, 8) each with a behavioural
// expander stand-in, checked against a plain-array SHA-256 schedule model.
module tb_sha_message_schedule_ctrl;

  localparam int NI = 3;

  function automatic int depth_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 8;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Expander stand-in: shift the window and insert the next schedule word at index 0.
  function automatic logic [15:0][31:0] expand_step(input logic [15:0][31:0] h);
    logic [15:0][31:0] r;
    r[0] = ss1(h[1]) + h[6] + ss0(h[14]) + h[15];
    for (int i = 1; i < 16; i++) r[i] = h[i-1];
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]             rst;
  logic [NI-1:0]             blk_valid;
  logic [NI-1:0]             w_ready;
  logic [NI-1:0][15:0][31:0] blk;
  logic [NI-1:0]             blk_ready;
  logic [NI-1:0]             w_valid;
  logic [NI-1:0]             w_last;
  logic [NI-1:0]             busy;
  logic [NI-1:0][31:0]       w_data;
  logic [NI-1:0][5:0]        w_idx;
  logic [NI-1:0][15:0][31:0] hist_o;

  logic [31:0] ref_w [NI][64];
  logic [31:0] got   [64];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = depth_of(g);
    sha_message_schedule_ctrl_if bus ();
    logic [15:0][31:0] pipe [D];

    assign bus.blk_valid_i = blk_valid[g];
    assign bus.blk_i       = blk[g];
    assign bus.w_ready_i   = w_ready[g];
    assign bus.exp_hist_i  = pipe[D-1];
    assign blk_ready[g]    = bus.blk_ready_o;
    assign w_valid[g]      = bus.w_valid_o;
    assign w_data[g]       = bus.w_o;
    assign w_idx[g]        = bus.w_idx_o;
    assign w_last[g]       = bus.w_last_o;
    assign busy[g]         = bus.busy_o;
    assign hist_o[g]       = bus.exp_hist_o;

    always @(posedge clk) begin
      pipe[0] <= expand_step(bus.exp_hist_o);
      for (int s = 1; s < D; s++) pipe[s] <= pipe[s-1];
    end

    sha_message_schedule_ctrl #(.PIPELINE_DEPTH(D)) u_dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );
  end

  task automatic build_ref(input int k, input logic [15:0][31:0] b);
    for (int i = 0; i < 16; i++) ref_w[k][i] = b[i];
    for (int i = 16; i < 64; i++)
      ref_w[k][i] = ss1(ref_w[k][i-2]) + ref_w[k][i-7] + ss0(ref_w[k][i-15]) + ref_w[k][i-16];
  endtask

  function automatic logic [15:0][31:0] rand_block();
    logic [15:0][31:0] b;
    for (int i = 0; i < 16; i++) b[i] = $urandom();
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic accept_block(input int k, input logic [15:0][31:0] b, input bit keep);
    bit ok = 1'b0;
    blk[k]       = b;
    blk_valid[k] = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (blk_ready[k]) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!keep) blk_valid[k] = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept[%0d]: blk_ready never seen, required 1 within 200 cycles", k);
    end
  endtask

  // Consumes one block right after its accepting edge, checking every word.
  task automatic consume_block(input int k, input int pct, input int want_cycles);
    int idx_exp = 0;
    int cyc = 0;
    int budget = 0;
    bit started = 1'b0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    bit ready_bad = 1'b0;
    logic [31:0] pd;
    logic [5:0] pi;
    logic pl;
    logic [15:0][31:0] ph;
    while (!done && budget < 5000) begin
      w_ready[k] = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      @(negedge clk);
      budget++;
      if (blk_ready[k]) ready_bad = 1'b1;
      if (budget == 1) begin
        n_tests++;
        if (w_valid[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL first_valid[%0d]: w_valid=%b one cycle after accept, required 1", k, w_valid[k]);
        end
      end
      if (w_valid[k]) started = 1'b1;
      if (started) cyc++;
      if (prev_stall) begin
        n_tests++;
        if (w_valid[k] !== 1'b1 || w_data[k] !== pd || w_idx[k] !== pi || w_last[k] !== pl || hist_o[k] !== ph) begin
          n_fail++;
          $display("FAIL stall_stable[%0d]: valid=%b idx=%0d data=%h, required 1 idx=%0d data=%h unchanged window",
                   k, w_valid[k], w_idx[k], w_data[k], pi, pd);
        end
      end
      if (w_valid[k]) begin
        n_tests++;
        if (w_idx[k] !== 6'(idx_exp) || w_data[k] !== ref_w[k][idx_exp] || w_last[k] !== (idx_exp == 63)) begin
          n_fail++;
          $display("FAIL word[%0d]: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   k, w_idx[k], w_data[k], w_last[k], idx_exp, ref_w[k][idx_exp], (idx_exp == 63));
        end
        if (w_ready[k]) begin
          got[idx_exp] = w_data[k];
          if (idx_exp == 63) done = 1'b1;
          idx_exp++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          pd = w_data[k]; pi = w_idx[k]; pl = w_last[k]; ph = hist_o[k];
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
    end
    w_ready[k] = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL block_done[%0d]: only %0d words accepted, required 64 within 5000 cycles", k, idx_exp);
    end
    n_tests++;
    if (ready_bad) begin
      n_fail++;
      $display("FAIL ready_busy[%0d]: blk_ready=1 during block, required 0", k);
    end
    if (want_cycles >= 0) begin
      n_tests++;
      if (cyc != want_cycles) begin
        n_fail++;
        $display("FAIL block_cycles[%0d]: %0d cycles, required %0d", k, cyc, want_cycles);
      end
    end
  endtask

  task automatic test_reset();
    rst = '1;
    blk_valid = '1;
    w_ready = '1;
    for (int k = 0; k < NI; k++) blk[k] = rand_block();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (blk_ready[k] !== 1'b0 || w_valid[k] !== 1'b0 || w_data[k] !== 32'd0 || w_idx[k] !== 6'd0 ||
            w_last[k] !== 1'b0 || busy[k] !== 1'b0 || hist_o[k] !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs[%0d]: ready=%b valid=%b data=%h idx=%0d last=%b busy=%b, required all 0",
                   k, blk_ready[k], w_valid[k], w_data[k], w_idx[k], w_last[k], busy[k]);
        end
      end
    end
    @(posedge clk); #1;
    rst = '0;
    blk_valid = '0;
    w_ready = '0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (blk_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_after_reset[%0d]: ready=%b busy=%b, required 1 0", k, blk_ready[k], busy[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    logic [15:0][31:0] b = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    build_ref(0, b);
    accept_block(0, b, 1'b0);
    consume_block(0, 100, 112);
    n_tests++;
    if (got[0] !== 32'h61626380 || got[15] !== 32'h00000018 || got[16] !== 32'h61626380 || got[17] !== 32'h000F0000) begin
      n_fail++;
      $display("FAIL abc_words: W0=%h W15=%h W16=%h W17=%h, required 61626380 00000018 61626380 000f0000",
               got[0], got[15], got[16], got[17]);
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0][31:0] b = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    build_ref(0, b);
    accept_block(0, b, 1'b0);
    consume_block(0, 30, -1);
    b = rand_block();
    build_ref(1, b);
    accept_block(1, b, 1'b0);
    consume_block(1, 30, -1);
  endtask

  task automatic test_depth_sweep();
    logic [15:0][31:0] b;
    for (int k = 0; k < NI; k++) begin
      b = rand_block();
      build_ref(k, b);
      accept_block(k, b, 1'b0);
      consume_block(k, 100, 16 + 48 * (depth_of(k) + 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0][31:0] a = rand_block();
    logic [15:0][31:0] b = rand_block();
    build_ref(1, a);
    accept_block(1, a, 1'b1);
    blk[1] = b;
    consume_block(1, 100, 16 + 48 * (depth_of(1) + 1));
    build_ref(1, b);
    @(negedge clk);
    n_tests++;
    if (blk_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready: ready=%b busy=%b the cycle after W63, required 1 0", blk_ready[1], busy[1]);
    end
    @(posedge clk); #1;
    blk_valid[1] = 1'b0;
    consume_block(1, 100, 16 + 48 * (depth_of(1) + 1));
  endtask

  task automatic test_reset_mid_op();
    logic [15:0][31:0] b = rand_block();
    bit hit = 1'b0;
    build_ref(2, b);
    accept_block(2, b, 1'b0);
    w_ready[2] = 1'b1;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (w_idx[2] == 6'd30 && !w_valid[2] && busy[2]) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_reset_reach: STEP at t=30 never seen, required within 2000 cycles");
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    w_ready[2] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (w_valid[2] !== 1'b0 || busy[2] !== 1'b0 || w_idx[2] !== 6'd0 || hist_o[2] !== '0 || blk_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: valid=%b busy=%b idx=%0d ready=%b, required 0 0 0 1 and cleared window",
               w_valid[2], busy[2], w_idx[2], blk_ready[2]);
    end
    @(posedge clk); #1;
    b = rand_block();
    build_ref(2, b);
    accept_block(2, b, 1'b0);
    consume_block(2, 100, 16 + 48 * (depth_of(2) + 1));
  endtask

  initial begin
    rst = '1;
    blk_valid = '0;
    w_ready = '0;
    blk = '0;
    test_reset();
    test_abc();
    test_back_pressure();
    test_depth_sweep();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
